// File: rtl/dm_pkg.sv
// dm_pkg: shared sizes, FSM states and alignment helper
// for the multi-cycle data memory controller.
package dm_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    function automatic logic dm_misalign(
        input logic [1:0] size,
        input logic [1:0] a
    );
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = a[0];
            SZ_W:    bad = (a != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dm_load_ext.sv
// dm_load_ext: picks the low byte/half/word of an
// LSB-aligned word and sign or zero extends it.
module dm_load_ext
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] res
);

    // Lane select plus extension; uns has no effect on words
    always_comb begin
        res = word;
        case (size)
            SZ_B:    res = {{24{~uns & word[7]}}, word[7:0]};
            SZ_H:    res = {{16{~uns & word[15]}}, word[15:0]};
            default: res = word;
        endcase
    end

endmodule

// File: rtl/dm_mc_ctrl.sv
// dm_mc_ctrl: byte-addressed little-endian data memory
// with req/done handshake and fixed wait states.
module dm_mc_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W   = 12,
    parameter int WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    dm_state_e         state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              go;
    logic              acc_we;
    logic [1:0]        acc_size;
    logic              acc_uns;
    logic [ADDR_W-1:0] a0, a1, a2, a3;
    logic [31:0]       acc_wdata;
    logic [31:0]       rd_word;
    logic [31:0]       ld_res;
    logic              bad;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^addr[31:ADDR_W];

    // With no wait states the access happens on the accept edge,
    // so the live inputs stand in for the latched fields
    always_comb begin
        if (WAIT_CYC == 0) begin
            acc_we    = we;
            acc_size  = size;
            acc_uns   = uns;
            a0        = addr[ADDR_W-1:0];
            acc_wdata = wdata;
        end else begin
            acc_we    = we_q;
            acc_size  = size_q;
            acc_uns   = uns_q;
            a0        = addr_q;
            acc_wdata = wdata_q;
        end
    end

    assign a1      = a0 + ADDR_W'(1);
    assign a2      = a0 + ADDR_W'(2);
    assign a3      = a0 + ADDR_W'(3);
    assign rd_word = {mem[a3], mem[a2], mem[a1], mem[a0]};
    assign bad     = dm_misalign(acc_size, a0[1:0]);

    dm_load_ext u_ext (
        .word (rd_word),
        .size (acc_size),
        .uns  (acc_uns),
        .res  (ld_res)
    );

    // Next-state, request latch and response computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        done_d  = 1'b0;
        go      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d    = we;
                    size_d  = size;
                    uns_d   = uns;
                    addr_d  = addr[ADDR_W-1:0];
                    wdata_d = wdata;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_RESP;
                        go      = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'(WAIT_CYC - 1);
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                    go      = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (go) begin
            done_d  = 1'b1;
            err_d   = bad;
            rdata_d = (bad || acc_we) ? 32'd0 : ld_res;
        end
    end

    // Control and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Store commit on the edge entering RESP; reset cancels it
    always_ff @(posedge clk) begin
        if (rst_n && go && acc_we && !bad) begin
            mem[a0] <= acc_wdata[7:0];
            if (acc_size != SZ_B) begin
                mem[a1] <= acc_wdata[15:8];
            end
            if (acc_size == SZ_W) begin
                mem[a2] <= acc_wdata[23:16];
                mem[a3] <= acc_wdata[31:24];
            end
        end
    end

    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: doc/dm_mc_ctrl.md
Name: dm_mc_ctrl

Overview:
- Parametrised, byte-addressed, little-endian data memory with a request/done handshake and programmable wait states.
- Used by the multi-cycle CPU datapath.
- Supports byte, halfword and word loads and stores, with sign or zero extension on loads.
- Detects misaligned accesses and reports them as errors without touching memory.

Parameters:
- ADDR_W, 12, byte-address bits used; depth = 2**ADDR_W bytes (default 4096).
- WAIT_CYC, 2, wait cycles between request acceptance and the response cycle (0..15).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load.
- size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
- uns  input  1  load zero-extend when 1, sign-extend when 0.
- addr  input  32  byte address; only bits [ADDR_W-1:0] are used, upper bits are ignored (wrap modulo depth).
- wdata  input  32  store data, LSB-aligned: byte uses [7:0], half uses [15:0].
- rdata  output  32  load result; valid in the done cycle.
- done  output  1  one-cycle response pulse.
- err  output  1  valid with done; misaligned or reserved-size access.
- busy  output  1  state != IDLE.

Behaviour:
- Single clock domain, clk. Reset rst_n is synchronous and active-low.
- Reset values: state = IDLE, done = 0, err = 0, rdata = 0, busy = 0, wait counter = 0. Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, req = 1:
  - Latch we, size, uns, addr[ADDR_W-1:0] and wdata.
  - Go to WAIT with counter = WAIT_CYC-1, or to RESP directly if WAIT_CYC = 0.
- IDLE, req = 0: stay in IDLE.
- WAIT: decrement the counter; go to RESP on the edge where the counter equals 0.
- Access point:
  - The memory access is performed on the clock edge that enters RESP, using the latched fields.
  - If WAIT_CYC = 0, the live inputs are equivalent to the latched fields.
- RESP: lasts exactly one cycle, with done = 1; then go to IDLE.
- Latency: req sampled high in cycle N gives done in cycle N+1+WAIT_CYC.
- Throughput: at most one access per WAIT_CYC+2 cycles.
- req while busy: ignored, not queued. The requester holds req until it sees done, then drops it.
- Stores (at the edge entering RESP):
  - Byte writes mem[a].
  - Half writes mem[a] = wdata[7:0], mem[a+1] = wdata[15:8].
  - Word writes mem[a..a+3], little-endian.
  - rdata = 0 in the done cycle.
- Loads:
  - Byte result is mem[a] extended to 32 bits.
  - Half result is {mem[a+1], mem[a]} extended to 32 bits.
  - Word result is {mem[a+3], mem[a+2], mem[a+1], mem[a]}.
  - Extension is sign when uns = 0, zero when uns = 1; uns is ignored for word loads.
- Error conditions:
  - Half access with a[0] = 1.
  - Word access with a[1:0] != 0.
  - size = 11.
- Error response: no write occurs, rdata = 0, err = 1 with done. Error responses take the same latency as normal accesses.
- Alignment guarantees that a legal access never wraps past the top of memory.
- rdata and err hold their values after done until the next RESP; only the done cycle is meaningful.
- Reset mid-operation: the FSM returns to IDLE, a pending store is discarded (memory unchanged), and no done is produced.
- Reset asserted in the RESP cycle: the write has already committed; outputs clear on the next edge.

Decomposition:
- Package dm_pkg contains:
  - Size constants SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10.
  - State encodings ST_IDLE, ST_WAIT, ST_RESP.
  - A function that computes misalignment from size and a[1:0].
- One sub-module, dm_load_ext: combinational byte/half/word extraction and sign/zero extension, from a 32-bit word plus size and uns to a 32-bit result.

Test Plan:
- Reset, then idle: rdata = 0, done = 0, busy = 0. Default WAIT_CYC = 2, req in cycle 5: done in cycle 8 exactly, single pulse.
- Word store 0xDEADBEEF at 0x10, then byte loads:
  - 0x10 with uns = 0 returns 0xFFFFFFEF.
  - 0x10 with uns = 1 returns 0x000000EF.
  - 0x13 with uns = 1 returns 0x000000DE.
- Half store 0x8001 at 0x22, then half loads:
  - 0x22 with uns = 0 returns 0xFFFF8001.
  - 0x22 with uns = 1 returns 0x00008001.
  - Word load at 0x20 shows 0x8001 in bits [31:16].
- Misaligned word store at 0x05 with 0x12345678:
  - done with err = 1.
  - Subsequent word load at 0x04 returns the prior contents unchanged.
  - size = 11 also gives err = 1.
- Address wrap: byte store 0xAA at 0x00001000 (ADDR_W = 12); byte load at 0x000 with uns = 1 returns 0x000000AA.
- Reset mid-operation and busy handling:
  - Assert rst_n = 0 during WAIT of a store 0x55 to 0x40: load at 0x40 returns the old value and no done appears.
  - req pulses while busy are ignored, and exactly one done is produced per accepted request.
